// File: rtl/adc_sar_mux_model.sv
// -----------------------------------------------------------------------------
// adc_sar_mux_model
//
// Purpose:
//   Cycle-accurate digital stand-in for the analog ADC endpoint: a NUM_CH:1
//   bitline MUX followed by a single 8-bit successive-approximation ADC.
//   The controller pulses adc_start with bl_sel pointing at a channel; the
//   selected level (as registered in the previous cycle) is captured, reduced
//   by OFFSET with saturation at zero, and converted MSB-first over 8 cycles.
//   The result appears on bl_data together with a one-cycle adc_done pulse
//   nine cycles after the start request.
//
// Ports:
//   clk          in   1               single clock
//   rst          in   1               asynchronous, active-high reset
//   bl_level     in   NUM_CH x IN_W   per-channel digital bitline level
//   bl_sel       in   SEL_W           MUX select from the controller
//   adc_start    in   1               single-cycle conversion request
//   bl_data      out  8               last conversion result (held)
//   adc_done     out  1               one-cycle pulse, bl_data valid from it on
//   adc_busy     out  1               high while a conversion is in flight
//   err_overrun  out  1               sticky: start seen while busy or done
//   err_sel      out  1               sticky: start seen with bl_sel >= NUM_CH
// -----------------------------------------------------------------------------
module adc_sar_mux_model #(
  parameter int NUM_CH = 10,
  parameter int IN_W   = 12,
  parameter int OFFSET = 0,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0][IN_W-1:0]      bl_level,
  input  logic [SEL_W-1:0]                 bl_sel,
  input  logic                             adc_start,
  output logic [7:0]                       bl_data,
  output logic                             adc_done,
  output logic                             adc_busy,
  output logic                             err_overrun,
  output logic                             err_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0] OFFSET_C = IN_W'(OFFSET);

  state_t            state_q;
  logic [IN_W-1:0]   mux_q;
  logic [IN_W-1:0]   mux_d;
  logic [IN_W-1:0]   hold_q;
  logic [IN_W-1:0]   hold_d;
  logic [7:0]        trial_q;
  logic [7:0]        trial_d;
  logic [2:0]        bit_idx_q;
  logic [7:0]        bl_data_q;
  logic              adc_done_q;
  logic              adc_busy_q;
  logic              err_overrun_q;
  logic              err_sel_q;

  logic                         sel_valid;
  logic [NUM_CH-1:0][IN_W-1:0]  chan_masked;
  logic [IN_W-1:0]              trial_ext;
  logic [7:0]                   bit_mask;
  logic                         keep_bit;

  // ---------------------------------------------------------------------------
  // Bitline MUX. Each channel is gated by its own select decode and the gated
  // values are OR-ed together, so an out-of-range select yields zero without
  // ever indexing past the end of bl_level.
  // ---------------------------------------------------------------------------
  assign sel_valid = (32'(bl_sel) < NUM_CH);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign chan_masked[gi] = (32'(bl_sel) == gi) ? bl_level[gi] : '0;
    end
  endgenerate

  always_comb begin
    mux_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mux_d = mux_d | chan_masked[i];
    end
  end

  // Offset removal with saturation at zero, applied at capture time.
  always_comb begin
    hold_d = '0;
    if (mux_q >= OFFSET_C) begin
      hold_d = mux_q - OFFSET_C;
    end
  end

  // ---------------------------------------------------------------------------
  // SAR step. The 8-bit trial code is aligned to the top of the IN_W-bit held
  // level, so the final code is the floor of the top 8 bits of hold_q.
  // ---------------------------------------------------------------------------
  assign trial_ext = IN_W'(trial_q) << (IN_W - 8);
  assign keep_bit  = (trial_ext <= hold_q);
  assign bit_mask  = 8'd1 << bit_idx_q;

  always_comb begin
    trial_d = trial_q;
    if (!keep_bit) begin
      trial_d = trial_d & ~bit_mask;
    end
    // Tentatively set the next lower bit; nothing left to try after bit 0.
    if (bit_idx_q != 3'd0) begin
      trial_d = trial_d | (bit_mask >> 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mux_q         <= '0;
      hold_q        <= '0;
      trial_q       <= '0;
      bit_idx_q     <= '0;
      bl_data_q     <= '0;
      adc_done_q    <= 1'b0;
      adc_busy_q    <= 1'b0;
      err_overrun_q <= 1'b0;
      err_sel_q     <= 1'b0;
    end else begin
      // One-cycle settle: the conversion sees the channel selected a cycle ago.
      mux_q <= mux_d;

      case (state_q)
        IDLE: begin
          adc_done_q <= 1'b0;
          if (adc_start) begin
            hold_q     <= hold_d;
            trial_q    <= 8'h80;
            bit_idx_q  <= 3'd7;
            adc_busy_q <= 1'b1;
            state_q    <= CONV;
            if (!sel_valid) begin
              err_sel_q <= 1'b1;
            end
          end
        end

        CONV: begin
          if (adc_start) begin
            err_overrun_q <= 1'b1;
          end
          trial_q <= trial_d;
          if (bit_idx_q == 3'd0) begin
            bl_data_q  <= trial_d;
            adc_done_q <= 1'b1;
            adc_busy_q <= 1'b0;
            state_q    <= DONE;
          end else begin
            bit_idx_q <= bit_idx_q - 3'd1;
          end
        end

        DONE: begin
          // A start landing on the done cycle is dropped, not queued.
          if (adc_start) begin
            err_overrun_q <= 1'b1;
          end
          adc_done_q <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          adc_done_q <= 1'b0;
          adc_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bl_data     = bl_data_q;
  assign adc_done    = adc_done_q;
  assign adc_busy    = adc_busy_q;
  assign err_overrun = err_overrun_q;
  assign err_sel     = err_sel_q;

endmodule

// File: tb/tb_adc_sar_mux_model.sv
// -----------------------------------------------------------------------------
// tb_adc_sar_mux_model
//
// Drives two instances of adc_sar_mux_model from the same stimulus, one with
// OFFSET=0 and one with OFFSET=16, and compares them against a reference that
// computes each code as floor(max(level - OFFSET, 0) / 16).
// -----------------------------------------------------------------------------
module tb_adc_sar_mux_model;

  localparam int NUM_CH = 10;
  localparam int IN_W   = 12;
  localparam int SEL_W  = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH-1:0][IN_W-1:0]  bl_level;
  logic [SEL_W-1:0]             bl_sel;
  logic                         adc_start;

  logic [7:0] data0, data1;
  logic       done0, done1, busy0, busy1, ovr0, ovr1, esel0, esel1;

  int checks = 0;
  int errors = 0;
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  always #5 clk = ~clk;

  adc_sar_mux_model #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OFFSET(0)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .bl_level    (bl_level),
    .bl_sel      (bl_sel),
    .adc_start   (adc_start),
    .bl_data     (data0),
    .adc_done    (done0),
    .adc_busy    (busy0),
    .err_overrun (ovr0),
    .err_sel     (esel0)
  );

  adc_sar_mux_model #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OFFSET(16)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .bl_level    (bl_level),
    .bl_sel      (bl_sel),
    .adc_start   (adc_start),
    .bl_data     (data1),
    .adc_done    (done1),
    .adc_busy    (busy1),
    .err_overrun (ovr1),
    .err_sel     (esel1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: offset removal saturating at zero, then keep the top 8 of 12 bits.
  function automatic logic [7:0] ref_code(input int level, input int offset);
    int v;
    v = level - offset;
    if (v < 0) v = 0;
    return 8'(v / 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select sel_prev for one cycle, then pulse adc_start with sel_now on bl_sel.
  // Returns in the cycle after the start was sampled (T+1).
  task automatic start_conv(input int sel_prev, input int sel_now);
    bl_sel = SEL_W'(sel_prev);
    tick();
    bl_sel    = SEL_W'(sel_now);
    adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
  endtask

  // Walks cycles T+1..T+10 checking busy, done, held data and the final code.
  // If overrun_at is nonzero, a second start is pulsed in cycle T+overrun_at.
  task automatic finish_conv(input string tag, input logic [7:0] exp0,
                             input logic [7:0] exp1, input int overrun_at);
    for (int i = 1; i <= 8; i++) begin
      chk({tag, "_busy0"}, 32'(busy0), 32'd1);
      chk({tag, "_busy1"}, 32'(busy1), 32'd1);
      chk({tag, "_early_done0"}, 32'(done0), 32'd0);
      chk({tag, "_held_data0"}, 32'(data0), 32'(last0));
      adc_start = (i == overrun_at);
      tick();
    end
    adc_start = 1'b0;
    chk({tag, "_done0"}, 32'(done0), 32'd1);
    chk({tag, "_done1"}, 32'(done1), 32'd1);
    chk({tag, "_busy_at_done0"}, 32'(busy0), 32'd0);
    chk({tag, "_data0"}, 32'(data0), 32'(exp0));
    chk({tag, "_data1"}, 32'(data1), 32'(exp1));
    $display("conv %s: data0=%h (exp %h) data1=%h (exp %h)", tag, data0, exp0, data1, exp1);
    tick();
    chk({tag, "_done_pulse0"}, 32'(done0), 32'd0);
    chk({tag, "_idle_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_keep_data0"}, 32'(data0), 32'(exp0));
    last0 = exp0;
    last1 = exp1;
  endtask

  task automatic run_chan(input string tag, input int ch);
    logic [7:0] e0, e1;
    e0 = ref_code(int'(bl_level[ch]), 0);
    e1 = ref_code(int'(bl_level[ch]), 16);
    start_conv(ch, ch);
    finish_conv(tag, e0, e1, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_data0"}, 32'(data0), 32'd0);
    chk({tag, "_data1"}, 32'(data1), 32'd0);
    chk({tag, "_done0"}, 32'(done0), 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
    chk({tag, "_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_ovr0"},  32'(ovr0),  32'd0);
    chk({tag, "_ovr1"},  32'(ovr1),  32'd0);
    chk({tag, "_esel0"}, 32'(esel0), 32'd0);
    chk({tag, "_esel1"}, 32'(esel1), 32'd0);
  endtask

  initial begin
    logic [7:0]        e0;
    logic [7:0]        e1;
    int                ch;
    logic [IN_W-1:0]   bnd [5];

    // ---- power-on reset ----
    rst       = 1'b1;
    bl_level  = '0;
    bl_sel    = '0;
    adc_start = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // ---- basic conversion on channel 3 ----
    bl_level[3] = 12'hA5F;
    run_chan("basic", 3);

    // ---- boundary levels on channel 0 ----
    bnd[0] = 12'h000;
    bnd[1] = 12'hFFF;
    bnd[2] = 12'h00F;
    bnd[3] = 12'h00A;
    bnd[4] = 12'h110;
    for (int b = 0; b < 5; b++) begin
      bl_level[0] = bnd[b];
      run_chan($sformatf("bound_%03h", bnd[b]), 0);
    end

    // ---- full 10-channel sweep, then back-to-back on the last channel ----
    for (int k = 0; k < NUM_CH; k++) begin
      bl_level[k] = IN_W'(k * 12'h111);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      run_chan($sformatf("sweep_ch%0d", k), k);
    end
    // Start in the first idle cycle after done: must be accepted, period 10.
    adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    finish_conv("back_to_back", ref_code(int'(bl_level[9]), 0),
                ref_code(int'(bl_level[9]), 16), 0);
    chk("sweep_ovr0",  32'(ovr0),  32'd0);
    chk("sweep_ovr1",  32'(ovr1),  32'd0);
    chk("sweep_esel0", 32'(esel0), 32'd0);
    chk("sweep_esel1", 32'(esel1), 32'd0);

    // ---- randomized levels and channels ----
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        bl_level[k] = IN_W'($urandom);
      end
      ch = int'($urandom_range(0, NUM_CH - 1));
      run_chan($sformatf("rand%0d_ch%0d", r, ch), ch);
    end

    // ---- select changes in the start cycle: previous channel is converted ----
    bl_level[2] = 12'h100;
    bl_level[7] = 12'h800;
    start_conv(2, 7);
    finish_conv("sel_timing", ref_code(32'h100, 0), ref_code(32'h100, 16), 0);
    chk("sel_timing_esel0", 32'(esel0), 32'd0);

    // ---- out-of-range select ----
    start_conv(12, 12);
    finish_conv("sel_invalid", ref_code(0, 0), ref_code(0, 16), 0);
    chk("sel_invalid_esel0", 32'(esel0), 32'd1);
    chk("sel_invalid_esel1", 32'(esel1), 32'd1);

    // ---- overrun plus level change after capture ----
    bl_level[5] = 12'hC3A;
    e0 = ref_code(32'hC3A, 0);
    e1 = ref_code(32'hC3A, 16);
    start_conv(5, 5);
    bl_level[5] = 12'h123;
    chk("overrun_pre_ovr0", 32'(ovr0), 32'd0);
    finish_conv("overrun", e0, e1, 4);
    chk("overrun_ovr0", 32'(ovr0), 32'd1);
    chk("overrun_ovr1", 32'(ovr1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("overrun_no_second_done0", 32'(done0), 32'd0);
      tick();
    end

    // ---- reset mid-conversion ----
    bl_level[1] = 12'hFFF;
    start_conv(1, 1);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk_quiet("reset_async");
    tick();
    chk_quiet("reset_held");
    rst   = 1'b0;
    last0 = 8'h00;
    last1 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("reset_abort_done0", 32'(done0), 32'd0);
      chk("reset_abort_done1", 32'(done1), 32'd0);
      chk("reset_abort_busy0", 32'(busy0), 32'd0);
    end
    run_chan("after_reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
